// File: rtl/stage4_row_sum_buffer.sv
// Softmax stage 4: row accumulator with ping-pong element buffer.
// Replays each closed row with its exact sum for the divider stage.
module stage4_row_sum_buffer #(
    parameter int ROW_LEN = 64,
    parameter int CNT_W   = $clog2(ROW_LEN),
    parameter int SUM_W   = 16 + CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_valid,
    input  logic [15:0]      i_pow_x,
    input  logic [15:0]      i_x_bypass,
    output logic             o_valid,
    output logic [15:0]      o_pow_x,
    output logic [15:0]      o_x_bypass,
    output logic [SUM_W-1:0] o_sum,
    output logic             o_last
);

    localparam int DEPTH = 2 << CNT_W;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ROW_LEN - 1);

    typedef enum logic {
        IDLE,
        REPLAY
    } rd_state_t;

    rd_state_t state;
    rd_state_t state_d;

    logic                  wr_bank;
    logic [CNT_W-1:0]      wr_cnt;
    logic [SUM_W-1:0]      acc;
    logic                  rd_bank;
    logic [CNT_W-1:0]      rd_cnt;
    logic [1:0]            bank_full;
    logic [1:0]            full_d;
    logic [1:0][SUM_W-1:0] sum_q;

    logic [31:0] mem [DEPTH];
    logic [31:0] rd_data;

    logic             wr_last;
    logic             rd_fire;
    logic             rd_last;
    logic [SUM_W-1:0] pow_ext;
    logic [SUM_W-1:0] acc_next;

    assign pow_ext  = {{CNT_W{1'b0}}, i_pow_x};
    assign acc_next = acc + pow_ext;
    assign wr_last  = (wr_cnt == LAST);
    assign rd_data  = mem[{rd_bank, rd_cnt}];

    always_comb begin
        state_d = state;
        rd_fire = 1'b0;
        rd_last = 1'b0;
        unique case (state)
            IDLE: begin
                if (bank_full[rd_bank]) state_d = REPLAY;
            end
            REPLAY: begin
                rd_fire = 1'b1;
                rd_last = (rd_cnt == LAST);
                // Chain straight into the other bank when it is already waiting.
                if (rd_last && !bank_full[~rd_bank]) state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        full_d = bank_full;
        if (i_valid && wr_last) full_d[wr_bank] = 1'b1;
        if (rd_fire && rd_last) full_d[rd_bank] = 1'b0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            wr_bank    <= 1'b0;
            wr_cnt     <= '0;
            acc        <= '0;
            rd_bank    <= 1'b0;
            rd_cnt     <= '0;
            bank_full  <= '0;
            sum_q      <= '0;
            o_valid    <= 1'b0;
            o_pow_x    <= '0;
            o_x_bypass <= '0;
            o_sum      <= '0;
            o_last     <= 1'b0;
        end else if (i_en) begin
            state     <= state_d;
            bank_full <= full_d;
            if (i_valid) begin
                if (wr_last) begin
                    sum_q[wr_bank] <= acc_next;
                    wr_bank        <= ~wr_bank;
                    wr_cnt         <= '0;
                    acc            <= '0;
                end else begin
                    wr_cnt <= wr_cnt + 1'b1;
                    acc    <= acc_next;
                end
            end
            if (rd_fire) begin
                o_valid    <= 1'b1;
                o_pow_x    <= rd_data[31:16];
                o_x_bypass <= rd_data[15:0];
                o_sum      <= sum_q[rd_bank];
                o_last     <= rd_last;
                if (rd_last) begin
                    rd_bank <= ~rd_bank;
                    rd_cnt  <= '0;
                end else begin
                    rd_cnt <= rd_cnt + 1'b1;
                end
            end else begin
                o_valid <= 1'b0;
                o_last  <= 1'b0;
            end
        end
    end

    // Element storage is deliberately left unreset.
    always_ff @(posedge i_clk) begin
        if (i_en && i_valid && !i_rst) begin
            mem[{wr_bank, wr_cnt}] <= {i_pow_x, i_x_bypass};
        end
    end

endmodule

// File: tb/tb_stage4_row_sum_buffer.sv
// Scoreboard bench for stage4_row_sum_buffer with ROW_LEN=4.
// Directed rows; a negedge monitor pops expected outputs.
module tb_stage4_row_sum_buffer;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_en;
    logic        i_valid;
    logic [15:0] i_pow_x;
    logic [15:0] i_x_bypass;
    logic        o_valid;
    logic [15:0] o_pow_x;
    logic [15:0] o_x_bypass;
    logic [17:0] o_sum;
    logic        o_last;

    stage4_row_sum_buffer #(.ROW_LEN(4)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_en       (i_en),
        .i_valid    (i_valid),
        .i_pow_x    (i_pow_x),
        .i_x_bypass (i_x_bypass),
        .o_valid    (o_valid),
        .o_pow_x    (o_pow_x),
        .o_x_bypass (o_x_bypass),
        .o_sum      (o_sum),
        .o_last     (o_last)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [15:0] p;
        logic [15:0] b;
        logic [17:0] s;
        logic        l;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   run_len = 0;
    int   max_run = 0;
    logic en_q = 1'b0;

    always @(posedge i_clk) en_q = i_en;

    always @(negedge i_clk) begin
        exp_t e;
        if (!i_rst && en_q) begin
            if (o_valid) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL spurious: got p=%h b=%h s=%h l=%b, required no output",
                             o_pow_x, o_x_bypass, o_sum, o_last);
                end else begin
                    e = q.pop_front();
                    if ({o_pow_x, o_x_bypass, o_sum, o_last} !== e) begin
                        bad++;
                        $display("FAIL out: got p=%h b=%h s=%h l=%b, required p=%h b=%h s=%h l=%b",
                                 o_pow_x, o_x_bypass, o_sum, o_last, e.p, e.b, e.s, e.l);
                    end
                end
            end else begin
                run_len = 0;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic expect_out(input logic [15:0] p, input logic [15:0] b,
                              input logic [17:0] s, input logic l);
        q.push_back('{p: p, b: b, s: s, l: l});
    endtask

    task automatic send(input logic [15:0] p, input logic [15:0] b);
        @(negedge i_clk);
        i_valid    = 1'b1;
        i_pow_x    = p;
        i_x_bypass = b;
    endtask

    task automatic idle();
        @(negedge i_clk);
        i_valid = 1'b0;
    endtask

    task automatic idle_check(input string name, input logic v);
        idle();
        check(name, 64'(o_valid), 64'(v));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 60) begin
            idle();
            n++;
        end
        check("drain", 64'(q.size()), 64'd0);
        q.delete();
        repeat (3) idle();
    endtask

    logic [48:0] held;

    initial begin
        i_rst = 1'b1;
        i_en = 1'b1;
        i_valid = 1'b0;
        i_pow_x = '0;
        i_x_bypass = '0;
        #12;
        check("reset_state", 64'({o_valid, o_pow_x, o_x_bypass, o_sum, o_last}), 64'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (2) idle();

        // single row with latency checks
        expect_out(16'h8000, 16'd1, 18'h0F000, 1'b0);
        expect_out(16'h4000, 16'd2, 18'h0F000, 1'b0);
        expect_out(16'h2000, 16'd3, 18'h0F000, 1'b0);
        expect_out(16'h1000, 16'd4, 18'h0F000, 1'b1);
        send(16'h8000, 16'd1);
        send(16'h4000, 16'd2);
        send(16'h2000, 16'd3);
        send(16'h1000, 16'd4);
        idle_check("lat_e1", 1'b0);
        idle_check("lat_e2", 1'b0);
        idle_check("lat_e3", 1'b1);
        drain();

        // overflow width
        for (int i = 0; i < 4; i++) expect_out(16'hFFFF, 16'hA0 + 16'(i), 18'h3FFFC, i == 3);
        for (int i = 0; i < 4; i++) send(16'hFFFF, 16'hA0 + 16'(i));
        drain();

        // continuous stream of three rows
        expect_out(16'h0001, 16'h10, 18'h0000A, 1'b0);
        expect_out(16'h0002, 16'h11, 18'h0000A, 1'b0);
        expect_out(16'h0003, 16'h12, 18'h0000A, 1'b0);
        expect_out(16'h0004, 16'h13, 18'h0000A, 1'b1);
        expect_out(16'h1000, 16'h14, 18'h0A000, 1'b0);
        expect_out(16'h2000, 16'h15, 18'h0A000, 1'b0);
        expect_out(16'h3000, 16'h16, 18'h0A000, 1'b0);
        expect_out(16'h4000, 16'h17, 18'h0A000, 1'b1);
        expect_out(16'hFFFF, 16'h18, 18'h20000, 1'b0);
        expect_out(16'h0001, 16'h19, 18'h20000, 1'b0);
        expect_out(16'h8000, 16'h1A, 18'h20000, 1'b0);
        expect_out(16'h8000, 16'h1B, 18'h20000, 1'b1);
        max_run = 0;
        send(16'h0001, 16'h10);
        send(16'h0002, 16'h11);
        send(16'h0003, 16'h12);
        send(16'h0004, 16'h13);
        send(16'h1000, 16'h14);
        send(16'h2000, 16'h15);
        send(16'h3000, 16'h16);
        send(16'h4000, 16'h17);
        send(16'hFFFF, 16'h18);
        send(16'h0001, 16'h19);
        send(16'h8000, 16'h1A);
        send(16'h8000, 16'h1B);
        drain();
        check("contiguous", 64'(max_run), 64'd12);

        // gapped input then a 3-cycle stall during replay
        expect_out(16'h0100, 16'hB0, 18'h00A00, 1'b0);
        expect_out(16'h0200, 16'hB1, 18'h00A00, 1'b0);
        expect_out(16'h0300, 16'hB2, 18'h00A00, 1'b0);
        expect_out(16'h0400, 16'hB3, 18'h00A00, 1'b1);
        send(16'h0100, 16'hB0);
        idle();
        send(16'h0200, 16'hB1);
        idle();
        send(16'h0300, 16'hB2);
        idle();
        send(16'h0400, 16'hB3);
        idle_check("gap_lat1", 1'b0);
        idle_check("gap_lat2", 1'b0);
        idle_check("gap_lat3", 1'b1);
        held = {o_valid, o_pow_x, o_x_bypass, o_last};
        i_en = 1'b0;
        i_valid = 1'b1;
        i_pow_x = 16'hDEAD;
        i_x_bypass = 16'hBEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            check("stall_hold", 64'({o_valid, o_pow_x, o_x_bypass, o_last}), 64'(held));
        end
        i_en = 1'b1;
        i_valid = 1'b0;
        drain();

        // reset mid-replay with a partial row in progress
        expect_out(16'h0011, 16'hD0, 18'h000AA, 1'b0);
        send(16'h0011, 16'hD0);
        send(16'h0022, 16'hD1);
        send(16'h0033, 16'hD2);
        send(16'h0044, 16'hD3);
        send(16'h7777, 16'hE0);
        send(16'h7777, 16'hE1);
        idle();
        #2;
        i_rst = 1'b1;
        #1;
        check("reset_async", 64'({o_valid, o_pow_x, o_x_bypass, o_sum, o_last}), 64'd0);
        check("reset_popped", 64'(q.size()), 64'd0);
        q.delete();
        @(negedge i_clk);
        i_rst = 1'b0;
        for (int i = 0; i < 4; i++) idle_check("post_reset_quiet", 1'b0);
        for (int i = 0; i < 4; i++) expect_out(16'h0100, 16'hC0 + 16'(i), 18'h00400, i == 3);
        for (int i = 0; i < 4; i++) send(16'h0100, 16'hC0 + 16'(i));
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stage4_row_sum_buffer.md
Name: stage4_row_sum_buffer

Overview:
Softmax-tree stage 4. It sits directly downstream of the pow2-approximation stage and consumes that stage's 16-bit pow values and 16-bit x bypass, one element per valid cycle. Each input row of ROW_LEN elements is accumulated into an exact sum while the elements are stored in a ping-pong buffer. After the row closes, every element is replayed together with its row sum, so the divider stage receives each numerator and its denominator in the same cycle.

Parameters:
ROW_LEN, 64, elements per softmax row; legal range 2..256.
CNT_W, $clog2(ROW_LEN), derived element-index width; not overridden.
SUM_W, 16+CNT_W, derived row-sum width.

Ports:
i_clk  input  1  clock; all state on rising edge
i_rst  input  1  reset, asynchronous, active-high
i_en  input  1  global pipeline enable; low freezes all state
i_valid  input  1  input element valid
i_pow_x  input  16  unsigned pow2 value from stage 3
i_x_bypass  input  16  x bypass from stage 3
o_valid  output  1  replayed element valid
o_pow_x  output  16  replayed pow value
o_x_bypass  output  16  replayed bypass value
o_sum  output  SUM_W  exact sum of all ROW_LEN pow values of the current row
o_last  output  1  high with element ROW_LEN-1 of a row

Behaviour:
- Reset (async, i_rst=1):
  - wr_bank, wr_cnt, acc, rd_bank and rd_cnt go to 0.
  - Both bank_full flags clear; read FSM goes to IDLE.
  - All outputs go to 0.
  - Buffer RAM contents are not reset.
  - A partial row in progress is discarded.
- i_en=0: no register, counter, FSM or RAM write changes; outputs hold. i_valid is ignored.
- Storage: two banks of ROW_LEN x 32 bits ({pow, bypass}) plus one SUM_W sum register per bank.
- Write side, on an enabled edge with i_valid=1:
  - Store {i_pow_x, i_x_bypass} at bank[wr_bank][wr_cnt].
  - acc += i_pow_x, zero-extended to SUM_W.
  - When wr_cnt = ROW_LEN-1:
    - sum[wr_bank] <= acc + i_pow_x.
    - bank_full[wr_bank] <= 1.
    - wr_bank toggles; wr_cnt <= 0; acc <= 0.
  - Otherwise wr_cnt increments.
- Arithmetic: exact, no saturation. ROW_LEN*0xFFFF always fits in SUM_W bits.
- Read FSM:
  - IDLE: go to REPLAY when bank_full[rd_bank]=1, with rd_cnt = 0.
  - REPLAY: each enabled cycle, read bank[rd_bank][rd_cnt] and increment rd_cnt.
    - The read of index ROW_LEN-1 clears bank_full[rd_bank], toggles rd_bank and sets rd_cnt to 0.
    - It then returns to IDLE, or stays in REPLAY if the other bank is already full (no bubble).
- Output register, on the enabled edge after each read:
  - o_valid <= 1.
  - o_pow_x and o_x_bypass <= the read data.
  - o_sum <= sum[rd_bank at read time].
  - o_last <= (read index = ROW_LEN-1).
  - On enabled cycles without a read, o_valid <= 0 and o_last <= 0; data outputs hold their last values.
- Latency: last element of a row sampled at enabled edge E.
  - Element 0 of that row is on the outputs after edge E+2.
  - Element j is on the outputs after edge E+2+j, counting enabled edges only.
- Throughput: one element per enabled cycle, sustained indefinitely.
  - Replay of row k completes before row k+2 can write bank k, so no stall or overrun path exists.
- Simultaneous events: write into one bank and read from the other in the same cycle is normal operation. A bank's full-set and full-clear never coincide.
- Reset mid-replay: the replay aborts immediately and o_valid drops asynchronously.

Test Plan:
- Reset: assert i_rst mid-stream -> o_valid=0, o_pow_x=0, o_x_bypass=0, o_sum=0, o_last=0 immediately. No output until a full new row is accepted.
- Single row, ROW_LEN=4: inputs 0x8000, 0x4000, 0x2000, 0x1000 with bypass 1..4, back-to-back -> two cycles after the last input:
  - Output is 4 consecutive valid cycles with the same pow and bypass order.
  - o_sum = 0x0F000 throughout; o_last high only with 0x1000.
- Overflow width, ROW_LEN=4: four inputs of 0xFFFF -> o_sum = 0x3FFFC (SUM_W=18) on all four outputs.
- Continuous stream, ROW_LEN=4: 3 rows (12 inputs) with i_valid held high -> 12 contiguous o_valid cycles, each row carrying its own correct sum, and o_last every 4th output.
- Gaps and stall: i_valid toggling 1,0,1,0 and i_en low for 3 cycles during replay -> outputs freeze while i_en=0. Order, sums and o_last are unaffected; latency counts enabled edges only.
- Partial row then reset, ROW_LEN=4: 2 inputs, reset, then 4 inputs of 0x0100 -> only the second row is replayed, with o_sum = 0x00400.
